// File: rtl/core_bus_arbiter.sv
//==============================================================================
// Module      : core_bus_arbiter
// Description : Shares one single-beat memory port between the core's ibus and
//               dbus. At most one transaction is outstanding, and responses are
//               routed back to whichever side was granted.
// Config      : ARB_ROUND_ROBIN_EN - when defined, a tie is won by the side
//               that was not granted last; otherwise dbus always wins a tie.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module core_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    // instruction bus
    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic                iresp_addr_ok,
    output logic                iresp_data_ok,
    output logic [DATA_W-1:0]   iresp_data,
    // data bus
    input  logic                dreq_valid,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_data,
    output logic                dresp_addr_ok,
    output logic                dresp_data_ok,
    output logic [DATA_W-1:0]   dresp_data,
    // memory port
    output logic                mreq_valid,
    output logic [ADDR_W-1:0]   mreq_addr,
    output logic [2:0]          mreq_size,
    output logic [DATA_W/8-1:0] mreq_strobe,
    output logic [DATA_W-1:0]   mreq_data,
    input  logic                mresp_addr_ok,
    input  logic                mresp_data_ok,
    input  logic [DATA_W-1:0]   mresp_data,
    // status
    output logic                busy,
    output logic                grant_d
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mreq_valid;
    logic [ADDR_W-1:0]   r_mreq_addr;
    logic [2:0]          r_mreq_size;
    logic [STRB_W-1:0]   r_mreq_strobe;
    logic [DATA_W-1:0]   r_mreq_data;
    logic                r_grant_d;

    logic                w_any_req;
    logic                w_win_d;
    logic                w_in_addr;
    logic                w_in_xfer;

    assign w_any_req = ireq_valid | dreq_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers the side granted most recently; resets to ibus so the first tie goes to dbus.
    logic r_last_d;

    assign w_win_d = dreq_valid & (~ireq_valid | ~r_last_d);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_d <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_d <= w_win_d;
        end
    end
`else
    assign w_win_d = dreq_valid;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_mreq_valid  <= 1'b0;
            r_mreq_addr   <= '0;
            r_mreq_size   <= 3'd0;
            r_mreq_strobe <= '0;
            r_mreq_data   <= '0;
            r_grant_d     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_d    <= w_win_d;
                        r_mreq_valid <= 1'b1;
                        r_state      <= S_ADDR;
                        if (w_win_d) begin
                            r_mreq_addr   <= dreq_addr;
                            r_mreq_size   <= dreq_size;
                            r_mreq_strobe <= dreq_strobe;
                            r_mreq_data   <= dreq_data;
                        end else begin
                            r_mreq_addr   <= ireq_addr;
                            r_mreq_size   <= 3'd2;
                            r_mreq_strobe <= '0;
                            r_mreq_data   <= '0;
                        end
                    end
                end
                S_ADDR: begin
                    // A same-cycle data_ok completes the transfer without visiting S_DATA.
                    if (mresp_addr_ok) begin
                        r_mreq_valid <= 1'b0;
                        r_state      <= mresp_data_ok ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (mresp_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_mreq_valid <= 1'b0;
                end
            endcase
        end
    end

    assign w_in_addr = (r_state == S_ADDR);
    assign w_in_xfer = (r_state == S_ADDR) | (r_state == S_DATA);

    assign iresp_addr_ok = mresp_addr_ok & w_in_addr & ~r_grant_d;
    assign dresp_addr_ok = mresp_addr_ok & w_in_addr &  r_grant_d;
    assign iresp_data_ok = mresp_data_ok & w_in_xfer & ~r_grant_d;
    assign dresp_data_ok = mresp_data_ok & w_in_xfer &  r_grant_d;
    assign iresp_data    = mresp_data;
    assign dresp_data    = mresp_data;

    assign mreq_valid  = r_mreq_valid;
    assign mreq_addr   = r_mreq_addr;
    assign mreq_size   = r_mreq_size;
    assign mreq_strobe = r_mreq_strobe;
    assign mreq_data   = r_mreq_data;
    assign busy        = (r_state != S_IDLE);
    assign grant_d     = r_grant_d;

endmodule

`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
//==============================================================================
// Module      : tb_core_bus_arbiter
// Description : Scoreboard bench for core_bus_arbiter with core-side drivers and
//               a latency-programmable memory responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_core_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        mreq_valid;
    logic [31:0] mreq_addr;
    logic [2:0]  mreq_size;
    logic [3:0]  mreq_strobe;
    logic [31:0] mreq_data;
    logic        mresp_addr_ok, mresp_data_ok;
    logic [31:0] mresp_data;
    logic        busy, grant_d;

    core_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
        .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
        .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data),
        .busy(busy), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        d;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    txn_t exp_q[$];
    txn_t dat_q[$];

    int checks = 0;
    int errors = 0;
    int addr_lat = 0;
    int data_lat = 0;
    bit mem_manual = 1'b0;
    bit mon_en = 1'b0;
    bit mutate_d = 1'b0;
    bit drop_d = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mk_i(input logic [31:0] addr, input logic [31:0] rdata);
        txn_t t;
        t.d = 1'b0; t.addr = addr; t.size = 3'd2; t.strobe = 4'd0; t.wdata = 32'd0; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t mk_d(input logic [31:0] addr, input logic [2:0] size,
                                  input logic [3:0] strobe, input logic [31:0] wdata,
                                  input logic [31:0] rdata);
        txn_t t;
        t.d = 1'b1; t.addr = addr; t.size = size; t.strobe = strobe; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    // Core-side drivers: present the head of each request queue, held until accepted.
    initial begin
        ireq_valid = 1'b0; ireq_addr = '0;
        dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
        forever begin
            @(posedge clk); #1;
            if (iq.size() > 0) begin
                ireq_valid = 1'b1;
                ireq_addr  = iq[0].addr;
            end else begin
                ireq_valid = 1'b0;
            end
            if (dq.size() > 0 && !drop_d) begin
                if (mutate_d && dreq_valid) begin
                    dreq_data = $urandom;
                end else begin
                    dreq_addr   = dq[0].addr;
                    dreq_size   = dq[0].size;
                    dreq_strobe = dq[0].strobe;
                    dreq_data   = dq[0].wdata;
                end
                dreq_valid = 1'b1;
            end else begin
                dreq_valid = 1'b0;
            end
        end
    end

    // Memory responder with programmable address/data latency.
    initial begin
        int          m_phase;
        int          m_cnt;
        logic [31:0] m_rdata;
        m_phase = 0; m_cnt = 0; m_rdata = '0;
        mresp_addr_ok = 1'b0; mresp_data_ok = 1'b0; mresp_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!resetn || mem_manual) begin
                m_phase = 0;
                m_cnt   = 0;
                if (!mem_manual) begin
                    mresp_addr_ok = 1'b0;
                    mresp_data_ok = 1'b0;
                end
            end else begin
                mresp_addr_ok = 1'b0;
                mresp_data_ok = 1'b0;
                if (m_phase == 0) begin
                    if (mreq_valid) begin
                        m_cnt++;
                        if (m_cnt > addr_lat) begin
                            mresp_addr_ok = 1'b1;
                            m_cnt   = 0;
                            m_rdata = (exp_q.size() > 0) ? exp_q[0].rdata : 32'd0;
                            if (data_lat == 0) begin
                                mresp_data_ok = 1'b1;
                                mresp_data    = m_rdata;
                            end else begin
                                m_phase = 1;
                            end
                        end
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt >= data_lat) begin
                        mresp_data_ok = 1'b1;
                        mresp_data    = m_rdata;
                        m_phase = 0;
                        m_cnt   = 0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: request fields, grant routing and response routing.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk); #1;
            if (mon_en && resetn) begin
                if (mreq_valid) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        chk("grant_d", {63'd0, grant_d}, {63'd0, e.d});
                        chk("mreq_addr", {32'd0, mreq_addr}, {32'd0, e.addr});
                        chk("mreq_size", {61'd0, mreq_size}, {61'd0, e.size});
                        chk("mreq_strobe", {60'd0, mreq_strobe}, {60'd0, e.strobe});
                        if (e.d) chk("mreq_data", {32'd0, mreq_data}, {32'd0, e.wdata});
                    end else begin
                        chk("mreq_unexpected", 64'd1, 64'd0);
                    end
                end
                if (mresp_addr_ok || iresp_addr_ok || dresp_addr_ok) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("addr_ok_route", {62'd0, iresp_addr_ok, dresp_addr_ok},
                            {62'd0, mresp_addr_ok & ~e.d, mresp_addr_ok & e.d});
                        dat_q.push_back(e);
                        if (e.d && dq.size() > 0) void'(dq.pop_front());
                        if (!e.d && iq.size() > 0) void'(iq.pop_front());
                    end else begin
                        chk("addr_ok_unexpected", 64'd1, 64'd0);
                    end
                end
                if (mresp_data_ok || iresp_data_ok || dresp_data_ok) begin
                    if (dat_q.size() > 0) begin
                        e = dat_q.pop_front();
                        chk("data_ok_route", {62'd0, iresp_data_ok, dresp_data_ok},
                            {62'd0, mresp_data_ok & ~e.d, mresp_data_ok & e.d});
                        chk("resp_data", {32'd0, e.d ? dresp_data : iresp_data}, {32'd0, e.rdata});
                    end else begin
                        chk("data_ok_unexpected", 64'd1, 64'd0);
                    end
                end
            end
        end
    end

    task automatic clear_queues();
        iq.delete(); dq.delete(); exp_q.delete(); dat_q.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        resetn = 1'b0;
        clear_queues();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_mreq_valid", {63'd0, mreq_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant_d", {63'd0, grant_d}, 64'd0);
        chk("rst_mreq_fields", {mreq_addr, mreq_data}, 64'd0);
        resetn = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || exp_q.size() > 0 || dat_q.size() > 0 || busy)
               && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            chk("drain_timeout", 64'd1, 64'd0);
            clear_queues();
        end
    endtask

    initial begin
        txn_t t;
        int   n;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        do_reset();

        // 1: ibus fetch, addr_ok one cycle late, data two cycles after that
        addr_lat = 1; data_lat = 2;
        t = mk_i(32'h8000_0000, 32'h1234_5678);
        iq.push_back(t); exp_q.push_back(t);
        @(negedge clk); #1;
        chk("lat_sample_cycle", {63'd0, mreq_valid}, 64'd0);
        @(negedge clk); #1;
        chk("lat_next_cycle", {63'd0, mreq_valid}, 64'd1);
        drain(50);

        // 2: dbus halfword write, addr_ok and data_ok together
        addr_lat = 0; data_lat = 0;
        t = mk_d(32'h10, 3'd1, 4'b0011, 32'h0000_BEEF, 32'hA5A5_0001);
        dq.push_back(t); exp_q.push_back(t);
        n = 0;
        while (!dresp_data_ok && n < 20) begin @(negedge clk); #1; n++; end
        chk("t2_same_cycle_ok", {62'd0, dresp_addr_ok, dresp_data_ok}, 64'd3);
        @(negedge clk); #1;
        chk("t2_idle_after", {63'd0, busy}, 64'd0);
        drain(50);

        // 3: three ties in a row
        do_reset();
        addr_lat = 0; data_lat = 1;
        iq.push_back(mk_i(32'h0000_1000, 32'h1111_1111));
        dq.push_back(mk_d(32'h200, 3'd2, 4'b0000, 32'd0, 32'h2222_0001));
        dq.push_back(mk_d(32'h204, 3'd2, 4'b1111, 32'hCAFE_0002, 32'h2222_0002));
        dq.push_back(mk_d(32'h208, 3'd0, 4'b0000, 32'd0, 32'h2222_0003));
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(dq[0]); exp_q.push_back(iq[0]);
        exp_q.push_back(dq[1]); exp_q.push_back(dq[2]);
`else
        exp_q.push_back(dq[0]); exp_q.push_back(dq[1]);
        exp_q.push_back(dq[2]); exp_q.push_back(iq[0]);
`endif
        drain(100);

        // 4: reset while a dbus read waits in S_DATA, then a stray data_ok
        addr_lat = 0; data_lat = 6;
        t = mk_d(32'h300, 3'd2, 4'b0000, 32'd0, 32'h3333_3333);
        dq.push_back(t); exp_q.push_back(t);
        n = 0;
        while (!(busy && !mreq_valid) && n < 20) begin @(negedge clk); #1; n++; end
        chk("t4_reached_data", {63'd0, grant_d}, 64'd1);
        mon_en = 1'b0; mem_manual = 1'b1;
        mresp_addr_ok = 1'b0; mresp_data_ok = 1'b0;
        #1 resetn = 1'b0;
        clear_queues();
        #1;
        chk("t4_rst_mreq_valid", {63'd0, mreq_valid}, 64'd0);
        chk("t4_rst_busy", {63'd0, busy}, 64'd0);
        chk("t4_rst_grant_d", {63'd0, grant_d}, 64'd0);
        @(posedge clk);
        @(negedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #1;
        mresp_data_ok = 1'b1; mresp_addr_ok = 1'b1; mresp_data = 32'hDEAD_BEEF;
        #1;
        chk("t4_late_data_ok", {60'd0, iresp_data_ok, dresp_data_ok, iresp_addr_ok, dresp_addr_ok}, 64'd0);
        @(negedge clk); #1;
        mresp_data_ok = 1'b0; mresp_addr_ok = 1'b0;
        chk("t4_idle_ignores", {63'd0, busy}, 64'd0);
        mem_manual = 1'b0; mon_en = 1'b1;

        // 5: memory stalls addr_ok for 10 cycles while the requester alters its data and drops valid
        addr_lat = 10; data_lat = 1;
        t = mk_d(32'h400, 3'd2, 4'b1111, 32'h5A5A_1234, 32'h4444_4444);
        dq.push_back(t); exp_q.push_back(t);
        mutate_d = 1'b1;
        n = 0;
        while (!mreq_valid && n < 20) begin @(negedge clk); #1; n++; end
        n = 0;
        while (mreq_valid && n < 30) begin
            n++;
            if (n == 4) drop_d = 1'b1;
            if (dresp_addr_ok) break;
            @(negedge clk); #1;
        end
        chk("t5_hold_cycles", n, 64'd11);
        drain(50);
        mutate_d = 1'b0; drop_d = 1'b0;

        // random single-requester traffic with varied latency
        for (int k = 0; k < 10; k++) begin
            addr_lat = $urandom_range(0, 3);
            data_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                t = mk_d($urandom, 3'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom);
                dq.push_back(t);
            end else begin
                t = mk_i($urandom, $urandom);
                iq.push_back(t);
            end
            exp_q.push_back(t);
            drain(50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
